// File: rtl/hwpe_tcdm_port_arbiter_if.sv
// ============================================================================
// Module      : hwpe_tcdm_port_arbiter_if
// Description : Bundles the N_IN accelerator-side TCDM ports and the single
//               memory-side TCDM port of the port arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface hwpe_tcdm_port_arbiter_if #(
    parameter int N_IN       = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int c_BE_W = DATA_WIDTH / 8;

    // accelerator side
    logic [N_IN-1:0]            in_req_i;
    logic [N_IN-1:0]            in_gnt_o;
    logic [N_IN*ADDR_WIDTH-1:0] in_add_i;
    logic [N_IN-1:0]            in_wen_i;
    logic [N_IN*c_BE_W-1:0]     in_be_i;
    logic [N_IN*DATA_WIDTH-1:0] in_wdata_i;
    logic [DATA_WIDTH-1:0]      in_r_rdata_o;
    logic [N_IN-1:0]            in_r_valid_o;

    // memory side
    logic                       out_req_o;
    logic                       out_gnt_i;
    logic [ADDR_WIDTH-1:0]      out_add_o;
    logic                       out_wen_o;
    logic [c_BE_W-1:0]          out_be_o;
    logic [DATA_WIDTH-1:0]      out_wdata_o;
    logic [DATA_WIDTH-1:0]      out_r_rdata_i;
    logic                       out_r_valid_i;

    // arbiter view
    modport slave (
        input  in_req_i, in_add_i, in_wen_i, in_be_i, in_wdata_i,
        output in_gnt_o, in_r_rdata_o, in_r_valid_o,
        output out_req_o, out_add_o, out_wen_o, out_be_o, out_wdata_o,
        input  out_gnt_i, out_r_rdata_i, out_r_valid_i
    );

    // environment view (accelerator masters + memory)
    modport master (
        output in_req_i, in_add_i, in_wen_i, in_be_i, in_wdata_i,
        input  in_gnt_o, in_r_rdata_o, in_r_valid_o,
        input  out_req_o, out_add_o, out_wen_o, out_be_o, out_wdata_o,
        output out_gnt_i, out_r_rdata_i, out_r_valid_i
    );
endinterface

`default_nettype wire

// File: rtl/hwpe_tcdm_port_arbiter.sv
// ============================================================================
// Module      : hwpe_tcdm_port_arbiter
// Description : Round-robin arbiter sharing one TCDM port among N_IN masters,
//               with winner lock until grant and in-order response routing.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hwpe_tcdm_port_arbiter #(
    parameter int N_IN            = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_ni,
    hwpe_tcdm_port_arbiter_if.slave   bus,
    output logic                      busy_o,
    output logic                      err_o
);
    localparam int c_ID_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int c_PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_BE_W  = DATA_WIDTH / 8;

    logic [c_ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic               lock_q, lock_d;
    logic [c_ID_W-1:0]  win_q, win_d;
    logic [c_ID_W-1:0]  fifo_q [MAX_OUTSTANDING];
    logic [c_ID_W-1:0]  fifo_d [MAX_OUTSTANDING];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [c_ID_W-1:0]  rr_win;
    logic [c_ID_W-1:0]  win;
    logic               full;
    logic               handshake;
    logic               pop;

    // Round-robin search starting at rr_ptr; modulo keeps non-power-of-2 N_IN correct.
    always_comb begin
        rr_win = rr_ptr_q;
        for (int k = N_IN - 1; k >= 0; k--) begin
            if (bus.in_req_i[(int'(rr_ptr_q) + k) % N_IN]) begin
                rr_win = c_ID_W'((int'(rr_ptr_q) + k) % N_IN);
            end
        end
    end

    assign win       = lock_q ? win_q : rr_win;
    assign full      = (cnt_q == c_CNT_W'(MAX_OUTSTANDING));
    assign handshake = bus.out_req_o & bus.out_gnt_i;
    assign pop       = bus.out_r_valid_i & (cnt_q != '0);

    assign bus.out_req_o    = (|bus.in_req_i) & ~full;
    assign bus.out_add_o    = bus.in_add_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus.out_wen_o    = bus.in_wen_i[win];
    assign bus.out_be_o     = bus.in_be_i[int'(win)*c_BE_W +: c_BE_W];
    assign bus.out_wdata_o  = bus.in_wdata_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
    assign bus.in_r_rdata_o = bus.out_r_rdata_i;

    always_comb begin
        bus.in_gnt_o = '0;
        if (handshake) begin
            bus.in_gnt_o[win] = 1'b1;
        end
    end

    always_comb begin
        bus.in_r_valid_o = '0;
        if (pop) begin
            bus.in_r_valid_o[fifo_q[rd_ptr_q]] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        lock_d   = lock_q;
        win_d    = win_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q | (bus.out_r_valid_i & (cnt_q == '0));

        if (handshake) begin
            lock_d           = 1'b0;
            fifo_d[wr_ptr_q] = win;
            wr_ptr_d         = wr_ptr_q + c_PTR_W'(1);
            rr_ptr_d         = (win == c_ID_W'(N_IN - 1)) ? '0 : win + c_ID_W'(1);
        end else if (bus.out_req_o) begin
            // Memory stalled: freeze the current winner until it is granted.
            lock_d = 1'b1;
            win_d  = win;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
        cnt_d = cnt_q + c_CNT_W'(handshake) - c_CNT_W'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            lock_q   <= 1'b0;
            win_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            lock_q   <= lock_d;
            win_q    <= win_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            fifo_q   <= fifo_d;
        end
    end

    assign busy_o = (cnt_q != '0) | (|bus.in_req_i);
    assign err_o  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_hwpe_tcdm_port_arbiter.sv
// ============================================================================
// Module      : tb_hwpe_tcdm_port_arbiter
// Description : Directed scoreboard bench for the TCDM port arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_hwpe_tcdm_port_arbiter;
    localparam int c_N  = 4;
    localparam int c_AW = 32;
    localparam int c_DW = 32;
    localparam int c_MO = 4;

    typedef struct {
        int          id;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;   // active-low reset line driving rst_ni
    logic busy, err;

    int n_vec = 0;
    int n_err = 0;

    int   gnt_q[$];
    rsp_t rsp_q[$];

    logic [c_AW-1:0] addr_tab  [c_N];
    logic [c_DW-1:0] wdata_tab [c_N];
    logic [3:0]      be_tab    [c_N];
    logic [c_N-1:0]  wen_tab;

    always #5 clk = ~clk;

    hwpe_tcdm_port_arbiter_if #(.N_IN(c_N), .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) bus ();

    hwpe_tcdm_port_arbiter #(
        .N_IN(c_N), .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .MAX_OUTSTANDING(c_MO)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst),
        .bus    (bus.slave),
        .busy_o (busy),
        .err_o  (err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic gnt, input logic rv,
                         input logic [31:0] rd);
        bus.in_req_i      = req;
        bus.out_gnt_i     = gnt;
        bus.out_r_valid_i = rv;
        bus.out_r_rdata_i = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_gnt(input int id);
        gnt_q.push_back(id);
    endtask

    task automatic exp_rsp(input int id, input logic [31:0] d);
        rsp_t r;
        r.id   = id;
        r.data = d;
        rsp_q.push_back(r);
    endtask

    task automatic do_reset();
        drive(4'b0000, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    // Monitor: whenever the DUT grants or returns a response, pop and compare.
    always @(negedge clk) begin
        if (bus.in_gnt_o != '0) begin
            if (gnt_q.size() == 0) begin
                chk("gnt_unexpected", 64'(bus.in_gnt_o), 64'h0);
            end else begin
                int id;
                logic [c_N-1:0] oh;
                id = gnt_q.pop_front();
                oh = c_N'(1) << id;
                chk("in_gnt_o",    64'(bus.in_gnt_o),    64'(oh));
                chk("out_add_o",   64'(bus.out_add_o),   64'(addr_tab[id]));
                chk("out_wen_o",   64'(bus.out_wen_o),   64'(wen_tab[id]));
                chk("out_be_o",    64'(bus.out_be_o),    64'(be_tab[id]));
                chk("out_wdata_o", 64'(bus.out_wdata_o), 64'(wdata_tab[id]));
            end
        end
        if (bus.in_r_valid_o != '0) begin
            if (rsp_q.size() == 0) begin
                chk("rvalid_unexpected", 64'(bus.in_r_valid_o), 64'h0);
            end else begin
                rsp_t r;
                logic [c_N-1:0] oh;
                r  = rsp_q.pop_front();
                oh = c_N'(1) << r.id;
                chk("in_r_valid_o", 64'(bus.in_r_valid_o), 64'(oh));
                chk("in_r_rdata_o", 64'(bus.in_r_rdata_o), 64'(r.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        wen_tab = 4'b0101;
        for (int i = 0; i < c_N; i++) begin
            addr_tab[i]  = 32'h1C00_0000 + 32'(i) * 32'h10;
            wdata_tab[i] = 32'hA5A5_0000 + 32'(i);
            be_tab[i]    = 4'hF >> i;
            bus.in_add_i[i*c_AW +: c_AW]   = addr_tab[i];
            bus.in_wdata_i[i*c_DW +: c_DW] = wdata_tab[i];
            bus.in_be_i[i*4 +: 4]          = be_tab[i];
        end
        bus.in_wen_i = wen_tab;
        drive(4'b0000, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        step();
        step();

        chk("reset_out_req",  64'(bus.out_req_o),    64'h0);
        chk("reset_in_gnt",   64'(bus.in_gnt_o),     64'h0);
        chk("reset_rvalid",   64'(bus.in_r_valid_o), 64'h0);
        chk("reset_busy",     64'(busy),             64'h0);
        chk("reset_err",      64'(err),              64'h0);
        rst = 1'b1;
        step();

        // single master read, response next cycle
        drive(4'b0001, 1'b1, 1'b0, 32'h0);
        exp_gnt(0);
        step();
        drive(4'b0000, 1'b0, 1'b1, 32'hDEAD_BEEF);
        exp_rsp(0, 32'hDEAD_BEEF);
        step();
        // rr_ptr is now 1: master 1 beats master 0
        drive(4'b0011, 1'b1, 1'b0, 32'h0);
        exp_gnt(1);
        step();
        drive(4'b0001, 1'b1, 1'b1, 32'h1111_0001);
        exp_gnt(0);
        exp_rsp(1, 32'h1111_0001);
        step();
        drive(4'b0000, 1'b0, 1'b1, 32'h1111_0000);
        exp_rsp(0, 32'h1111_0000);
        step();

        // all four requesting continuously, rr_ptr=1
        for (int k = 0; k < 5; k++) begin
            drive(4'b1111, 1'b1, k > 0, 32'h2000_0000 + 32'(k));
            exp_gnt((1 + k) % 4);
            if (k > 0) exp_rsp((k) % 4, 32'h2000_0000 + 32'(k));
            step();
        end
        drive(4'b0000, 1'b0, 1'b1, 32'h2000_0005);
        exp_rsp(1, 32'h2000_0005);
        step();

        // lock: masters 0 and 2, memory stalls 3 cycles
        do_reset();
        drive(4'b0101, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("lock_out_req", 64'(bus.out_req_o), 64'h1);
            chk("lock_out_add", 64'(bus.out_add_o), 64'(addr_tab[0]));
            chk("lock_in_gnt",  64'(bus.in_gnt_o),  64'h0);
            step();
        end
        drive(4'b0101, 1'b1, 1'b0, 32'h0);
        exp_gnt(0);
        step();
        drive(4'b0100, 1'b1, 1'b1, 32'h3000_0000);
        exp_gnt(2);
        exp_rsp(0, 32'h3000_0000);
        step();
        drive(4'b0000, 1'b0, 1'b1, 32'h3000_0001);
        exp_rsp(2, 32'h3000_0001);
        step();

        // full: rr_ptr=3, four grants without responses
        for (int k = 0; k < 4; k++) begin
            drive(4'b1111, 1'b1, 1'b0, 32'h0);
            exp_gnt((3 + k) % 4);
            step();
        end
        drive(4'b1111, 1'b1, 1'b0, 32'h0);
        #2;
        chk("full_out_req", 64'(bus.out_req_o), 64'h0);
        chk("full_in_gnt",  64'(bus.in_gnt_o),  64'h0);
        chk("full_busy",    64'(busy),          64'h1);
        step();
        drive(4'b1111, 1'b1, 1'b1, 32'h4000_0000);
        exp_rsp(3, 32'h4000_0000);
        #2;
        chk("full_pop_same_cycle_req", 64'(bus.out_req_o), 64'h0);
        step();
        drive(4'b1111, 1'b1, 1'b0, 32'h0);
        exp_gnt(3);
        #2;
        chk("unfull_out_req", 64'(bus.out_req_o), 64'h1);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(4'b0000, 1'b0, 1'b1, 32'h4000_0001 + 32'(k));
            exp_rsp(k, 32'h4000_0001 + 32'(k));
            step();
        end
        drive(4'b0000, 1'b0, 1'b0, 32'h0);
        #2;
        chk("drained_busy", 64'(busy), 64'h0);
        step();

        // spurious response with empty FIFO
        drive(4'b0000, 1'b0, 1'b1, 32'hBAD0_BAD0);
        #2;
        chk("spurious_rvalid", 64'(bus.in_r_valid_o), 64'h0);
        chk("spurious_err_pre", 64'(err), 64'h0);
        step();
        drive(4'b0000, 1'b0, 1'b0, 32'h0);
        chk("spurious_err", 64'(err), 64'h1);
        step();
        step();
        step();
        chk("spurious_err_sticky", 64'(err), 64'h1);
        do_reset();
        chk("err_after_reset", 64'(err), 64'h0);

        // reset with two outstanding
        drive(4'b0011, 1'b1, 1'b0, 32'h0);
        exp_gnt(0);
        step();
        drive(4'b0010, 1'b1, 1'b0, 32'h0);
        exp_gnt(1);
        step();
        drive(4'b0000, 1'b0, 1'b0, 32'h0);
        #2;
        chk("outstanding_busy", 64'(busy), 64'h1);
        rst = 1'b0;
        bus.out_r_valid_i = 1'b1;
        #1;
        chk("midreset_out_req", 64'(bus.out_req_o),    64'h0);
        chk("midreset_in_gnt",  64'(bus.in_gnt_o),     64'h0);
        chk("midreset_rvalid",  64'(bus.in_r_valid_o), 64'h0);
        chk("midreset_busy",    64'(busy),             64'h0);
        chk("midreset_err",     64'(err),              64'h0);
        step();
        bus.out_r_valid_i = 1'b0;
        rst = 1'b1;
        step();
        chk("postreset_busy", 64'(busy), 64'h0);
        drive(4'b0011, 1'b1, 1'b0, 32'h0);
        exp_gnt(0);
        step();
        drive(4'b0010, 1'b1, 1'b1, 32'h6000_0000);
        exp_gnt(1);
        exp_rsp(0, 32'h6000_0000);
        step();
        drive(4'b0000, 1'b0, 1'b1, 32'h6000_0001);
        exp_rsp(1, 32'h6000_0001);
        step();
        drive(4'b0000, 1'b0, 1'b0, 32'h0);
        step();
        step();

        chk("pending_grants",    64'(gnt_q.size()), 64'h0);
        chk("pending_responses", 64'(rsp_q.size()), 64'h0);
        chk("final_err",         64'(err),          64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
